// File: rtl/ps2_mouse_device_pkg.sv
// Shared definitions for the PS/2 mouse device: FSM state encodings,
// host command / device response byte values, frame geometry and parity helper.
package ps2_mouse_device_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    TX_HI        = 3'd1,
    TX_LO        = 3'd2,
    TX_GAP       = 3'd3,
    RX_LO        = 3'd4,
    RX_HI        = 3'd5,
    RX_ACK       = 3'd6,
    INHIBIT_WAIT = 3'd7
  } state_t;

  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_ENABLE    = 8'hF4;
  localparam logic [7:0] CMD_DISABLE   = 8'hF5;
  localparam logic [7:0] RSP_ACK       = 8'hFA;
  localparam logic [7:0] RSP_RESEND    = 8'hFE;
  localparam logic [7:0] RSP_SELF_TEST = 8'hAA;

  // start + 8 data + parity + stop
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned BIT_CNT_W  = 4;

  // Parity bit that makes the count of ones across data+parity odd
  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/ps2_mouse_device_frame_shifter.sv
// ps2_frame_shifter: 11-bit PS/2 frame serializer/deserializer with parity.
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   i_load/i_tx_byte- load a full device->host frame built from i_tx_byte
//   i_shift         - advance to the next transmit bit
//   i_clear         - clear before host->device reception
//   i_sample/i_rx_bit - shift one received bit in
//   o_tx_bit        - bit currently presented for transmission
//   o_rx_byte, o_rx_parity_ok, o_rx_stop_ok - decoded receive frame
module ps2_frame_shifter
  import ps2_mouse_device_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_tx_byte,
  input  logic       i_shift,
  input  logic       i_clear,
  input  logic       i_sample,
  input  logic       i_rx_bit,
  output logic       o_tx_bit,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_parity_ok,
  output logic       o_rx_stop_ok
);

  logic [FRAME_BITS-1:0] r_sr;

  // TX shifts out LSB first with 1s backfilled; RX shifts in at the top so
  // after 10 samples data sits in [8:1], parity in [9], stop in [10].
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= {1'b1, odd_parity(i_tx_byte), i_tx_byte, 1'b0};
    end else if (i_clear) begin
      r_sr <= '0;
    end else if (i_shift) begin
      r_sr <= {1'b1, r_sr[FRAME_BITS-1:1]};
    end else if (i_sample) begin
      r_sr <= {i_rx_bit, r_sr[FRAME_BITS-1:1]};
    end
  end

  assign o_tx_bit       = r_sr[0];
  assign o_rx_byte      = r_sr[8:1];
  assign o_rx_parity_ok = ^r_sr[9:1];
  assign o_rx_stop_ok   = r_sr[10];

endmodule

// File: rtl/ps2_mouse_device.sv
// ps2_mouse_device: PS/2 mouse device side. Transmits 3-byte movement packets,
// receives host commands, ACKs them and answers from a 3-entry response queue.
// Ports:
//   clk, reset                 - system clock, synchronous active-high reset
//   ps2_clk, ps2_data          - open-drain PS/2 lines (driven 0 or high-Z)
//   left/right/middle_button   - button states
//   x_move, y_move             - 9-bit two's-complement movement
//   send                       - one-cycle packet transmit request
//   busy, packet_sent          - packet in flight / packet finished pulse
//   streaming                  - data reporting enabled (host F4)
//   cmd_valid, cmd_byte        - good host command pulse / last good command
module ps2_mouse_device
  import ps2_mouse_device_pkg::*;
#(
  parameter int unsigned HALF_BIT_CLKS = 2000,
  parameter int unsigned GAP_CLKS      = 8000
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        ps2_clk,
  inout  wire        ps2_data,
  input  logic       left_button,
  input  logic       right_button,
  input  logic       middle_button,
  input  logic [8:0] x_move,
  input  logic [8:0] y_move,
  input  logic       send,
  output logic       busy,
  output logic       packet_sent,
  output logic       streaming,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte
);

  localparam int unsigned TMR_MAX = (GAP_CLKS > HALF_BIT_CLKS) ? GAP_CLKS : HALF_BIT_CLKS;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  state_t               r_state;
  logic [TMR_W-1:0]     r_timer;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic                 r_ack_phase;
  logic                 r_clk_low, r_data_low;
  logic                 r_clk_meta, r_clk_sync, r_data_meta, r_data_sync;
  logic                 r_tx_is_resp;
  logic [7:0]           r_pkt0, r_pkt1, r_pkt2;
  logic [1:0]           r_pkt_idx;
  logic [7:0]           r_q0, r_q1, r_q2;
  logic [1:0]           r_q_cnt;
  logic                 r_busy, r_packet_sent, r_streaming, r_cmd_valid;
  logic [7:0]           r_cmd_byte;
  logic                 r_sh_load, r_sh_shift, r_sh_clear, r_sh_sample, r_rx_bit;
  logic [7:0]           r_sh_byte;

  logic                 w_half_done, w_gap_done;
  logic [7:0]           w_pkt_byte;
  logic                 w_tx_bit, w_rx_par_ok, w_rx_stop_ok;
  logic [7:0]           w_rx_byte;

  // Open-drain drivers
  assign ps2_clk  = r_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = r_data_low ? 1'b0 : 1'bz;

  assign busy        = r_busy;
  assign packet_sent = r_packet_sent;
  assign streaming   = r_streaming;
  assign cmd_valid   = r_cmd_valid;
  assign cmd_byte    = r_cmd_byte;

  assign w_half_done = (r_timer == TMR_W'(HALF_BIT_CLKS - 1));
  assign w_gap_done  = (r_timer == TMR_W'(GAP_CLKS - 1));

  // Current packet byte
  always_comb begin
    w_pkt_byte = r_pkt0;
    case (r_pkt_idx)
      2'd1:    w_pkt_byte = r_pkt1;
      2'd2:    w_pkt_byte = r_pkt2;
      default: w_pkt_byte = r_pkt0;
    endcase
  end

  ps2_frame_shifter u_shifter (
    .clk            (clk),
    .reset          (reset),
    .i_load         (r_sh_load),
    .i_tx_byte      (r_sh_byte),
    .i_shift        (r_sh_shift),
    .i_clear        (r_sh_clear),
    .i_sample       (r_sh_sample),
    .i_rx_bit       (r_rx_bit),
    .o_tx_bit       (w_tx_bit),
    .o_rx_byte      (w_rx_byte),
    .o_rx_parity_ok (w_rx_par_ok),
    .o_rx_stop_ok   (w_rx_stop_ok)
  );

  // Line synchronizers, protocol FSM, timers, packet latch and response queue
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_timer       <= '0;
      r_bit_cnt     <= '0;
      r_ack_phase   <= 1'b0;
      r_clk_low     <= 1'b0;
      r_data_low    <= 1'b0;
      r_clk_meta    <= 1'b1;
      r_clk_sync    <= 1'b1;
      r_data_meta   <= 1'b1;
      r_data_sync   <= 1'b1;
      r_tx_is_resp  <= 1'b0;
      r_pkt0        <= '0;
      r_pkt1        <= '0;
      r_pkt2        <= '0;
      r_pkt_idx     <= '0;
      r_q0          <= '0;
      r_q1          <= '0;
      r_q2          <= '0;
      r_q_cnt       <= '0;
      r_busy        <= 1'b0;
      r_packet_sent <= 1'b0;
      r_streaming   <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_cmd_byte    <= '0;
      r_sh_load     <= 1'b0;
      r_sh_shift    <= 1'b0;
      r_sh_clear    <= 1'b0;
      r_sh_sample   <= 1'b0;
      r_rx_bit      <= 1'b0;
      r_sh_byte     <= '0;
    end else begin
      r_clk_meta    <= ps2_clk;
      r_clk_sync    <= r_clk_meta;
      r_data_meta   <= ps2_data;
      r_data_sync   <= r_data_meta;
      r_packet_sent <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_sh_load     <= 1'b0;
      r_sh_shift    <= 1'b0;
      r_sh_clear    <= 1'b0;
      r_sh_sample   <= 1'b0;

      case (r_state)
        IDLE: begin
          r_clk_low  <= 1'b0;
          r_data_low <= 1'b0;
          r_timer    <= '0;
          r_bit_cnt  <= '0;
          // Host request-to-send wins over queued responses and packets
          if (r_clk_sync && !r_data_sync) begin
            r_sh_clear <= 1'b1;
            r_clk_low  <= 1'b1;
            r_state    <= RX_LO;
          end else if (r_clk_sync && r_q_cnt != 2'd0) begin
            r_sh_load    <= 1'b1;
            r_sh_byte    <= r_q0;
            r_tx_is_resp <= 1'b1;
            r_state      <= TX_HI;
          end else if (r_clk_sync && r_busy) begin
            r_sh_load    <= 1'b1;
            r_sh_byte    <= w_pkt_byte;
            r_tx_is_resp <= 1'b0;
            r_state      <= TX_HI;
          end else if (send && r_streaming && r_q_cnt == 2'd0 && !r_busy) begin
            r_busy    <= 1'b1;
            r_pkt_idx <= '0;
            r_pkt0    <= {2'b00, y_move[8], x_move[8], 1'b1,
                          middle_button, right_button, left_button};
            r_pkt1    <= x_move[7:0];
            r_pkt2    <= y_move[7:0];
          end
        end

        TX_HI: begin
          r_clk_low <= 1'b0;
          // Shifter output settles one cycle after load/shift
          if (r_timer != '0) r_data_low <= ~w_tx_bit;
          if (w_half_done) begin
            r_timer <= '0;
            if (!r_clk_sync) begin
              // Host inhibit: drop the frame and restart the packet later
              r_clk_low  <= 1'b0;
              r_data_low <= 1'b0;
              if (!r_tx_is_resp) r_pkt_idx <= '0;
              r_state <= INHIBIT_WAIT;
            end else begin
              r_clk_low <= 1'b1;
              r_state   <= TX_LO;
            end
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        TX_LO: begin
          if (w_half_done) begin
            r_timer   <= '0;
            r_clk_low <= 1'b0;
            if (r_bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
              r_data_low <= 1'b0;
              r_state    <= TX_GAP;
              if (r_tx_is_resp) begin
                r_q0    <= r_q1;
                r_q1    <= r_q2;
                r_q2    <= '0;
                r_q_cnt <= r_q_cnt - 2'd1;
              end else if (r_pkt_idx == 2'd2) begin
                r_pkt_idx     <= '0;
                r_busy        <= 1'b0;
                r_packet_sent <= 1'b1;
              end else begin
                r_pkt_idx <= r_pkt_idx + 2'd1;
              end
            end else begin
              r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
              r_sh_shift <= 1'b1;
              r_state    <= TX_HI;
            end
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        TX_GAP: begin
          r_clk_low  <= 1'b0;
          r_data_low <= 1'b0;
          if (w_gap_done) begin
            r_timer <= '0;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        INHIBIT_WAIT: begin
          r_clk_low  <= 1'b0;
          r_data_low <= 1'b0;
          // Gap timer only runs while the host leaves the clock released
          if (!r_clk_sync) begin
            r_timer <= '0;
          end else if (!r_data_sync) begin
            r_timer    <= '0;
            r_bit_cnt  <= '0;
            r_sh_clear <= 1'b1;
            r_clk_low  <= 1'b1;
            r_state    <= RX_LO;
          end else if (w_gap_done) begin
            r_timer <= '0;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        RX_LO: begin
          if (w_half_done) begin
            r_timer   <= '0;
            r_clk_low <= 1'b0;
            r_state   <= RX_HI;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        RX_HI: begin
          if (w_half_done) begin
            r_timer     <= '0;
            r_sh_sample <= 1'b1;
            r_rx_bit    <= r_data_sync;
            r_clk_low   <= 1'b1;
            if (r_bit_cnt == BIT_CNT_W'(FRAME_BITS - 2)) begin
              r_data_low  <= 1'b1;
              r_ack_phase <= 1'b0;
              r_state     <= RX_ACK;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
              r_state   <= RX_LO;
            end
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        RX_ACK: begin
          if (w_half_done) begin
            r_timer <= '0;
            if (!r_ack_phase) begin
              r_ack_phase <= 1'b1;
              r_clk_low   <= 1'b0;
            end else begin
              r_data_low <= 1'b0;
              r_state    <= TX_GAP;
              // A new command replaces any unsent responses
              r_q1 <= '0;
              r_q2 <= '0;
              if (w_rx_par_ok && w_rx_stop_ok) begin
                r_cmd_valid <= 1'b1;
                r_cmd_byte  <= w_rx_byte;
                r_q0        <= RSP_ACK;
                r_q_cnt     <= 2'd1;
                case (w_rx_byte)
                  CMD_RESET: begin
                    r_q1        <= RSP_SELF_TEST;
                    r_q2        <= 8'h00;
                    r_q_cnt     <= 2'd3;
                    r_streaming <= 1'b0;
                  end
                  CMD_ENABLE:  r_streaming <= 1'b1;
                  CMD_DISABLE: r_streaming <= 1'b0;
                  default: ;
                endcase
              end else begin
                r_q0    <= RSP_RESEND;
                r_q_cnt <= 2'd1;
              end
            end
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        default: begin
          r_clk_low  <= 1'b0;
          r_data_low <= 1'b0;
          r_timer    <= '0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_mouse_device.sv
// Directed bench for ps2_mouse_device: bus-functional PS/2 host with
// immediate-assertion checks at every comparison point.
module tb_ps2_mouse_device;

  localparam int unsigned HALF = 6;
  localparam int unsigned GAP  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       left_button = 1'b0, right_button = 1'b0, middle_button = 1'b0;
  logic [8:0] x_move = '0, y_move = '0;
  logic       send = 1'b0;
  logic       busy, packet_sent, streaming, cmd_valid;
  logic [7:0] cmd_byte;
  logic       h_clk_low = 1'b0, h_data_low = 1'b0;

  wire ps2_clk;
  wire ps2_data;
  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = h_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = h_data_low ? 1'b0 : 1'bz;

  ps2_mouse_device #(.HALF_BIT_CLKS(HALF), .GAP_CLKS(GAP)) dut (
    .clk           (clk),
    .reset         (reset),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .left_button   (left_button),
    .right_button  (right_button),
    .middle_button (middle_button),
    .x_move        (x_move),
    .y_move        (y_move),
    .send          (send),
    .busy          (busy),
    .packet_sent   (packet_sent),
    .streaming     (streaming),
    .cmd_valid     (cmd_valid),
    .cmd_byte      (cmd_byte)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   falls = 0;
  int   cv_cnt = 0;
  int   ps_cnt = 0;
  logic prev_line = 1'b1;
  logic busy_prev = 1'b0;
  logic busy_at_ps = 1'b1;
  logic busy_before_ps = 1'b0;

  // Event monitors sampled away from the active edge
  always @(negedge clk) begin
    if (prev_line === 1'b1 && ps2_clk === 1'b0) falls++;
    prev_line = ps2_clk;
    if (cmd_valid === 1'b1) cv_cnt++;
    if (packet_sent === 1'b1) begin
      ps_cnt++;
      busy_at_ps     = busy;
      busy_before_ps = busy_prev;
    end
    busy_prev = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic p;
    p = (^b) ? 1'b0 : 1'b1;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic wait_fall(input string tag);
    logic p;
    p = ps2_clk;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (p === 1'b1 && ps2_clk === 1'b0) return;
      p = ps2_clk;
    end
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed timeout expected ps2_clk fall", tag);
  endtask

  // Host receives one device frame, sampling data on each falling clock
  task automatic rx_frame(input string tag, input logic [7:0] exp);
    logic [10:0] f;
    f = '0;
    for (int i = 0; i < 11; i++) begin
      wait_fall(tag);
      f[i] = ps2_data;
    end
    check(tag, 32'(f), 32'(exp_frame(exp)));
  endtask

  // Host request-to-send followed by 10 bits and ACK check
  task automatic host_send(input string tag, input logic [7:0] b, input logic par);
    logic [9:0] bits;
    bits = {1'b1, par, b};
    h_clk_low = 1'b1;
    repeat (10) @(negedge clk);
    h_data_low = 1'b1;
    repeat (2) @(negedge clk);
    h_clk_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_fall(tag);
      h_data_low = ~bits[i];
    end
    wait_fall(tag);
    check({tag, "_ack_low"}, 32'(ps2_data), 32'd0);
    repeat (2 * HALF + 4) @(negedge clk);
    check({tag, "_ack_rel"}, 32'(ps2_data), 32'd1);
  endtask

  task automatic pulse_send();
    @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  int f0;

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    check("rst_clk",   32'(ps2_clk),     32'd1);
    check("rst_data",  32'(ps2_data),    32'd1);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_strm",  32'(streaming),   32'd0);
    check("rst_cv",    32'(cmd_valid),   32'd0);
    check("rst_cmd",   32'(cmd_byte),    32'd0);
    check("rst_ps",    32'(packet_sent), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Enable streaming
    host_send("f4", 8'hF4, 1'b0);
    rx_frame("f4_rsp", 8'hFA);
    check("f4_strm", 32'(streaming), 32'd1);
    check("f4_cmd",  32'(cmd_byte),  32'h0F4);
    check("f4_cv",   32'(cv_cnt),    32'd1);

    // Movement packet; inputs change after acceptance to prove latching
    repeat (40) @(negedge clk);
    left_button = 1'b1; x_move = 9'h1FF; y_move = 9'h005;
    pulse_send();
    check("pkt_busy", 32'(busy), 32'd1);
    left_button = 1'b0; x_move = 9'h000; y_move = 9'h000;
    rx_frame("pkt_b0", 8'h19);
    rx_frame("pkt_b1", 8'hFF);
    rx_frame("pkt_b2", 8'h05);
    repeat (20) @(negedge clk);
    check("pkt_ps_cnt",  32'(ps_cnt),         32'd1);
    check("pkt_busy_ps", 32'(busy_at_ps),     32'd0);
    check("pkt_busy_pr", 32'(busy_before_ps), 32'd1);
    check("pkt_busy_end", 32'(busy),          32'd0);

    // Host inhibit during byte1 forces a full retransmission
    repeat (40) @(negedge clk);
    left_button = 1'b1; x_move = 9'h1FF; y_move = 9'h005;
    pulse_send();
    rx_frame("inh_b0", 8'h19);
    for (int i = 0; i < 3; i++) wait_fall("inh_part");
    h_clk_low = 1'b1;
    repeat (50) @(negedge clk);
    check("inh_busy",   32'(busy),   32'd1);
    check("inh_ps_cnt", 32'(ps_cnt), 32'd1);
    h_clk_low = 1'b0;
    rx_frame("inh_r0", 8'h19);
    rx_frame("inh_r1", 8'hFF);
    rx_frame("inh_r2", 8'h05);
    repeat (20) @(negedge clk);
    check("inh_ps_end",   32'(ps_cnt), 32'd2);
    check("inh_busy_end", 32'(busy),   32'd0);

    // Bad parity command gets a resend request
    repeat (40) @(negedge clk);
    host_send("badpar", 8'hF4, 1'b1);
    rx_frame("badpar_rsp", 8'hFE);
    check("badpar_cv",   32'(cv_cnt),    32'd1);
    check("badpar_strm", 32'(streaming), 32'd1);
    check("badpar_cmd",  32'(cmd_byte),  32'h0F4);

    // Reset command: ACK, self-test, ID; streaming off
    repeat (40) @(negedge clk);
    host_send("ff", 8'hFF, 1'b1);
    rx_frame("ff_r0", 8'hFA);
    rx_frame("ff_r1", 8'hAA);
    rx_frame("ff_r2", 8'h00);
    check("ff_strm", 32'(streaming), 32'd0);
    check("ff_cmd",  32'(cmd_byte),  32'h0FF);
    check("ff_cv",   32'(cv_cnt),    32'd2);
    repeat (40) @(negedge clk);
    f0 = falls;
    pulse_send();
    repeat (100) @(negedge clk);
    check("nostrm_falls", 32'(falls - f0), 32'd0);
    check("nostrm_ps",    32'(ps_cnt),     32'd2);
    check("nostrm_busy",  32'(busy),       32'd0);

    // Reset during TX_LO releases the lines immediately
    host_send("f4b", 8'hF4, 1'b0);
    rx_frame("f4b_rsp", 8'hFA);
    repeat (40) @(negedge clk);
    pulse_send();
    wait_fall("rst_mid");
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_clk",  32'(ps2_clk),  32'd1);
    check("rstmid_data", 32'(ps2_data), 32'd1);
    check("rstmid_busy", 32'(busy),     32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    f0 = falls;
    repeat (200) @(negedge clk);
    check("rstmid_falls", 32'(falls - f0), 32'd0);
    check("rstmid_strm",  32'(streaming),  32'd0);
    check("rstmid_cmd",   32'(cmd_byte),   32'd0);
    check("rstmid_ps",    32'(ps_cnt),     32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_device.md
PS2_MOUSE_DEVICE -- requirements
Module: ps2_mouse_device

Interface
REQ-001 Parameter HALF_BIT_CLKS, default 2000, meaning clk cycles per PS/2 clock half-period (40 us at 50 MHz).
REQ-002 Parameter GAP_CLKS, default 8000, meaning idle clk cycles inserted after every transmitted frame.
REQ-003 Port clk, input, 1, system clock; reset, input, 1, synchronous, active-high.
REQ-004 Ports ps2_clk and ps2_data, inout, 1 each, open-drain: driven 0 or high-Z, never driven 1.
REQ-005 Ports left_button, right_button, middle_button, input, 1 each, button states.
REQ-006 Ports x_move and y_move, input, 9 each, two's-complement movement; bit 8 is the sign.
REQ-007 Port send, input, 1, one-cycle request to transmit a movement packet.
REQ-008 Port busy, output, 1, high from packet acceptance until packet_sent.
REQ-009 Port packet_sent, output, 1, one-cycle pulse after the third packet byte completes.
REQ-010 Port streaming, output, 1, set by host command F4.
REQ-011 Ports cmd_valid (output, 1, one-cycle pulse) and cmd_byte (output, 8, last good host command).

Function
REQ-012 ps2_clk and ps2_data inputs shall pass through a 2-flop synchronizer; all decisions use synchronized values.
REQ-013 Packet byte0 = {0,0,y_move[8],x_move[8],1,middle,right,left}, byte1 = x_move[7:0], byte2 = y_move[7:0]; all fields are latched on acceptance.
REQ-014 send is accepted only in IDLE with streaming=1 and the response queue empty; otherwise it is ignored and produces no packet_sent.
REQ-015 Every frame is 11 bits: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-016 Per transmitted bit: TX_HI drives the data bit with clock released for HALF_BIT_CLKS; TX_LO then holds ps2_clk low for HALF_BIT_CLKS.
REQ-017 At the last cycle of TX_HI, synchronized ps2_clk low means host inhibit: the frame is aborted, both lines are released, and the whole packet is retransmitted from byte0 once ps2_clk has been high for GAP_CLKS.
REQ-018 After each frame, TX_GAP releases both lines for GAP_CLKS before the next frame or IDLE.
REQ-019 In IDLE, synchronized ps2_data=0 with ps2_clk=1 starts reception; host reception outranks pending transmission.
REQ-020 RX clocking: RX_LO holds clock low for HALF_BIT_CLKS, then RX_HI releases it for HALF_BIT_CLKS; ps2_data is sampled on the last cycle of RX_HI.
REQ-021 RX collects 10 bits: 8 data, parity, stop; the 11th clock (RX_ACK) drives ps2_data low across a full low/high clock period, then releases it.
REQ-022 A good frame has odd parity and stop=1; it pulses cmd_valid and updates cmd_byte in the cycle RX_ACK ends.
REQ-023 Responses: FF -> queue FA,AA,00 and clear streaming; F4 -> FA and set streaming; F5 -> FA and clear streaming; any other good command -> FA; bad parity or stop -> FE with no cmd_valid.
REQ-024 The response queue holds at most 3 bytes, drains before any movement packet, and a new command flushes unsent entries.
REQ-025 A host request detected mid-packet (REQ-017 inhibit followed by data low) shall abort the packet, keep busy high, and retransmit after the response queue drains.
REQ-026 State set: IDLE, TX_HI, TX_LO, TX_GAP, RX_LO, RX_HI, RX_ACK, INHIBIT_WAIT; any unused encoding returns to IDLE.

Reset
REQ-027 reset shall force IDLE with both lines high-Z, busy=0, packet_sent=0, streaming=0, cmd_valid=0, cmd_byte=00, the queue empty, and all counters 0.
REQ-028 reset mid-frame shall release both lines within one clk cycle; no self-test AA is sent on reset.

Structure
REQ-029 A shared package shall hold the state encodings, command constants (FF, F4, F5, FA, FE, AA) and the frame length 11.
REQ-030 A sub-module ps2_frame_shifter shall perform 11-bit serialize/deserialize and parity; the FSM, timers and queue live at top level.

Verification
REQ-031 Host sends F4 -> device ACKs by driving data low on the 11th clock, then transmits FA; streaming=1, cmd_valid pulses with cmd_byte=F4.
REQ-032 streaming=1, send with left=1, x_move=1FF, y_move=005 -> host decodes bytes 19, FF, 05 with correct parity; packet_sent pulses once and busy falls the same cycle.
REQ-033 Host holds ps2_clk low during byte1 -> frame aborts; after release the host receives 19, FF, 05 again, complete from byte0.
REQ-034 Host sends F4 with even parity -> device transmits FE, cmd_valid stays 0, streaming is unchanged.
REQ-035 Host sends FF -> device transmits FA, AA, 00 and streaming=0; a following send produces no traffic and no packet_sent.
REQ-036 Assert reset during TX_LO -> ps2_clk is high-Z on the next cycle, busy=0, and no further edges occur.
